// File: rtl/wifi_cmd_rx_if.sv
// ============================================================================
//  Module      : wifi_cmd_rx_if
//  Description : Serial input and decoded command/debug outputs of the
//                ESP WiFi command receiver.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface wifi_cmd_rx_if;
    logic       rx;
    logic [2:0] cmd_code;
    logic       cmd_valid;
    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       frame_err;
    logic       busy;

    // Receiver side: consumes the serial line, produces decoded results.
    modport slave (
        input  rx,
        output cmd_code,
        output cmd_valid,
        output rx_byte,
        output byte_valid,
        output frame_err,
        output busy
    );

    // Host side: drives the serial line, observes decoded results.
    modport master (
        output rx,
        input  cmd_code,
        input  cmd_valid,
        input  rx_byte,
        input  byte_valid,
        input  frame_err,
        input  busy
    );
endinterface

`default_nettype wire

// File: rtl/wifi_cmd_rx.sv
// ============================================================================
//  Module      : wifi_cmd_rx
//  Description : 8N1 UART receiver with single-character command decode.
//                Decoded commands are held on cmd_code for HOLD_CYCLES
//                clocks; every well-framed byte is exposed on rx_byte.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module wifi_cmd_rx #(
    parameter int CLK_HZ      = 50000000,
    parameter int BAUD        = 9600,
    parameter int HOLD_CYCLES = 5000000
) (
    input  wire logic      clk,
    input  wire logic      reset,
    wifi_cmd_rx_if.slave   bus
);

    localparam int DIV    = CLK_HZ / BAUD;
    localparam int HALF   = DIV / 2;
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [DIV_W-1:0]  C_DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0]  C_HALF_LAST = DIV_W'(HALF - 1);
    localparam logic [HOLD_W-1:0] C_HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic              r_rx_meta;
    logic              r_rx_s;
    state_t            r_state;
    logic [DIV_W-1:0]  r_baud_cnt;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic [7:0]        r_rx_byte;
    logic              r_byte_valid;
    logic              r_frame_err;
    logic              r_cmd_valid;
    logic [2:0]        r_cmd_code;
    logic [HOLD_W-1:0] r_hold_cnt;

    // ------------------------------------------------------------------
    // Combinational next-state values
    // ------------------------------------------------------------------
    state_t            w_state_nxt;
    logic [DIV_W-1:0]  w_baud_nxt;
    logic [2:0]        w_bit_nxt;
    logic [7:0]        w_shift_nxt;
    logic              w_stop_ok;
    logic              w_stop_bad;
    logic              w_is_cmd;
    logic [2:0]        w_code;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= bus.rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Receive FSM state, baud/bit counters and data shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
        end
    end

    // Next-state logic: start qualification at mid-bit, then one sample per bit.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_stop_ok   = 1'b0;
        w_stop_bad  = 1'b0;

        case (r_state)
            IDLE: begin
                w_baud_nxt = '0;
                w_bit_nxt  = '0;
                if (!r_rx_s) begin
                    w_state_nxt = START;
                end
            end

            START: begin
                if (r_baud_cnt == C_HALF_LAST) begin
                    w_baud_nxt = '0;
                    // A line that is already high again was only a glitch.
                    w_state_nxt = r_rx_s ? IDLE : DATA;
                end else begin
                    w_baud_nxt = r_baud_cnt + 1'b1;
                end
            end

            DATA: begin
                if (r_baud_cnt == C_DIV_LAST) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {r_rx_s, r_shift[7:1]};
                    w_bit_nxt   = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = STOP;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + 1'b1;
                end
            end

            STOP: begin
                if (r_baud_cnt == C_DIV_LAST) begin
                    w_baud_nxt = '0;
                    if (r_rx_s) begin
                        w_stop_ok   = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_stop_bad  = 1'b1;
                        w_state_nxt = WAIT_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + 1'b1;
                end
            end

            WAIT_IDLE: begin
                // A held-low line (break) must not be taken as a new start bit.
                w_baud_nxt = '0;
                if (r_rx_s) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_baud_nxt  = '0;
                w_bit_nxt   = '0;
            end
        endcase
    end

    // Command decode of the completed shift register (valid during the stop sample).
    always_comb begin
        w_is_cmd = 1'b1;
        w_code   = 3'b000;
        case (r_shift)
            8'h49:   w_code = 3'b010;   // 'I' -> INACTIVE
            8'h41:   w_code = 3'b001;   // 'A' -> ACTIVE
            8'h45:   w_code = 3'b011;   // 'E' -> EMERGENCY
            8'h4C:   w_code = 3'b100;   // 'L' -> ALARM
            default: w_is_cmd = 1'b0;
        endcase
    end

    // Byte/frame result registers; all pulses line up on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_byte    <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_cmd_valid  <= 1'b0;
        end else begin
            r_byte_valid <= w_stop_ok;
            r_frame_err  <= w_stop_bad;
            r_cmd_valid  <= w_stop_ok & w_is_cmd;
            if (w_stop_ok) begin
                r_rx_byte <= r_shift;
            end
        end
    end

    // Hold timer: a new command reloads, otherwise count down and clear at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd_code <= 3'b000;
            r_hold_cnt <= '0;
        end else if (w_stop_ok && w_is_cmd) begin
            r_cmd_code <= w_code;
            r_hold_cnt <= C_HOLD_LOAD;
        end else if (r_hold_cnt != '0) begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
            if (r_hold_cnt == HOLD_W'(1)) begin
                r_cmd_code <= 3'b000;
            end
        end
    end

    assign bus.cmd_code   = r_cmd_code;
    assign bus.cmd_valid  = r_cmd_valid;
    assign bus.rx_byte    = r_rx_byte;
    assign bus.byte_valid = r_byte_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.busy       = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_wifi_cmd_rx.sv
// ============================================================================
//  Module      : tb_wifi_cmd_rx
//  Description : Directed self-checking bench for wifi_cmd_rx
//                (CLK_HZ=16, BAUD=1 -> 16 clocks per bit, HOLD_CYCLES=100).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wifi_cmd_rx;

    localparam int BIT  = 16;
    localparam int HOLD = 100;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    wifi_cmd_rx_if bus();

    wifi_cmd_rx #(
        .CLK_HZ      (16),
        .BAUD        (1),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Event monitor: counts pulses and timestamps command load / expiry.
    int         cyc = 0;
    int         n_cv = 0;
    int         n_bv = 0;
    int         n_fe = 0;
    int         last_cv_cyc = 0;
    int         zero_cyc = 0;
    logic [2:0] codes [0:31];
    logic [2:0] prev_code = 3'b000;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.cmd_valid === 1'b1) begin
            codes[n_cv[4:0]] = bus.cmd_code;
            n_cv = n_cv + 1;
            last_cv_cyc = cyc;
        end
        if (bus.byte_valid === 1'b1) n_bv = n_bv + 1;
        if (bus.frame_err === 1'b1)  n_fe = n_fe + 1;
        if (prev_code != 3'b000 && bus.cmd_code == 3'b000) zero_cyc = cyc;
        prev_code = bus.cmd_code;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one 8N1 frame; the line is left at the stop-bit level afterwards.
    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        @(negedge clk);
        bus.rx = 1'b0;
        clocks(BIT);
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            clocks(BIT);
        end
        bus.rx = stop_bit;
        clocks(BIT);
    endtask

    int cv0, bv0, fe0;

    initial begin
        bus.rx = 1'b1;
        clocks(3);
        #1;
        // Reset state
        chk("reset_cmd_code",   {29'd0, bus.cmd_code}, 32'd0);
        chk("reset_rx_byte",    {24'd0, bus.rx_byte},  32'd0);
        chk("reset_busy",       {31'd0, bus.busy},     32'd0);
        chk("reset_cmd_valid",  {31'd0, bus.cmd_valid},32'd0);
        @(negedge clk);
        reset = 1'b0;
        clocks(4);

        // 1: 'A' decodes to 001 and is held exactly HOLD clocks
        cv0 = n_cv; bv0 = n_bv;
        send_byte(8'h41, 1'b1);
        clocks(4);
        chk("t1_cv_count",  n_cv - cv0, 32'd1);
        chk("t1_bv_count",  n_bv - bv0, 32'd1);
        chk("t1_rx_byte",   {24'd0, bus.rx_byte}, 32'h41);
        chk("t1_code_at_cv",{29'd0, codes[cv0[4:0]]}, 32'd1);
        chk("t1_cmd_code",  {29'd0, bus.cmd_code}, 32'd1);
        clocks(HOLD + 10);
        chk("t1_expired",   {29'd0, bus.cmd_code}, 32'd0);
        chk("t1_hold_len",  zero_cyc - last_cv_cyc, HOLD);

        // 2: 'E' then 'I' started 40 clocks after the 'E' decode
        cv0 = n_cv;
        send_byte(8'h45, 1'b1);
        for (int k = 0; k < 200 && (cyc - last_cv_cyc) < 40; k++) @(negedge clk);
        chk("t2_gap_reached", ((cyc - last_cv_cyc) >= 40) ? 32'd1 : 32'd0, 32'd1);
        send_byte(8'h49, 1'b1);
        clocks(4);
        chk("t2_cv_count",  n_cv - cv0, 32'd2);
        chk("t2_first_code",{29'd0, codes[cv0[4:0]]}, 32'd3);
        chk("t2_second_code",{29'd0, codes[(cv0 + 1) & 31]}, 32'd2);
        chk("t2_cmd_code",  {29'd0, bus.cmd_code}, 32'd2);
        clocks(HOLD + 10);
        chk("t2_hold_len",  zero_cyc - last_cv_cyc, HOLD);

        // 3: non-command byte
        cv0 = n_cv; bv0 = n_bv;
        send_byte(8'h5A, 1'b1);
        clocks(4);
        chk("t3_bv_count",  n_bv - bv0, 32'd1);
        chk("t3_rx_byte",   {24'd0, bus.rx_byte}, 32'h5A);
        chk("t3_cv_count",  n_cv - cv0, 32'd0);
        chk("t3_cmd_code",  {29'd0, bus.cmd_code}, 32'd0);

        // 4: 'L' with bad stop bit, line held low for 3 further bit times
        cv0 = n_cv; bv0 = n_bv; fe0 = n_fe;
        send_byte(8'h4C, 1'b0);
        clocks(3 * BIT);
        chk("t4_wait_busy", {31'd0, bus.busy}, 32'd1);
        chk("t4_fe_count",  n_fe - fe0, 32'd1);
        chk("t4_bv_count",  n_bv - bv0, 32'd0);
        chk("t4_cmd_code",  {29'd0, bus.cmd_code}, 32'd0);
        bus.rx = 1'b1;
        clocks(5);
        chk("t4_idle_again",{31'd0, bus.busy}, 32'd0);
        send_byte(8'h41, 1'b1);
        clocks(4);
        chk("t4_a_cv_count",n_cv - cv0, 32'd1);
        chk("t4_a_code",    {29'd0, bus.cmd_code}, 32'd1);

        // 5: 5-clock glitch is rejected at the mid-start sample
        cv0 = n_cv; bv0 = n_bv; fe0 = n_fe;
        bus.rx = 1'b0;
        clocks(5);
        bus.rx = 1'b1;
        clocks(3);
        chk("t5_start_busy",{31'd0, bus.busy}, 32'd1);
        clocks(6);
        chk("t5_busy_drop", {31'd0, bus.busy}, 32'd0);
        chk("t5_no_events", (n_cv - cv0) + (n_bv - bv0) + (n_fe - fe0), 32'd0);

        // 6a: reset during data bits of 'E' (the earlier 'A' is still held)
        bus.rx = 1'b0;
        clocks(BIT);
        bus.rx = 1'b1;          // 'E' bit0
        clocks(BIT);
        bus.rx = 1'b0;          // 'E' bit1
        clocks(BIT / 2);
        chk("t6a_busy_pre", {31'd0, bus.busy}, 32'd1);
        chk("t6a_code_pre", {29'd0, bus.cmd_code}, 32'd1);
        reset = 1'b1;
        #1;
        chk("t6a_cmd_code", {29'd0, bus.cmd_code}, 32'd0);
        chk("t6a_rx_byte",  {24'd0, bus.rx_byte}, 32'd0);
        chk("t6a_busy",     {31'd0, bus.busy}, 32'd0);
        chk("t6a_pulses",   {29'd0, bus.cmd_valid, bus.byte_valid, bus.frame_err}, 32'd0);
        bus.rx = 1'b1;
        clocks(3);
        reset = 1'b0;
        clocks(3);
        cv0 = n_cv;
        send_byte(8'h41, 1'b1);
        clocks(4);
        chk("t6a_a_cv",     n_cv - cv0, 32'd1);
        chk("t6a_a_code",   {29'd0, bus.cmd_code}, 32'd1);
        chk("t6a_a_byte",   {24'd0, bus.rx_byte}, 32'h41);

        // 6b: reset during an active hold
        clocks(20);
        chk("t6b_held",     {29'd0, bus.cmd_code}, 32'd1);
        reset = 1'b1;
        #1;
        chk("t6b_cmd_code", {29'd0, bus.cmd_code}, 32'd0);
        chk("t6b_rx_byte",  {24'd0, bus.rx_byte}, 32'd0);
        clocks(3);
        reset = 1'b0;
        clocks(3);
        cv0 = n_cv;
        send_byte(8'h41, 1'b1);
        clocks(4);
        chk("t6b_a_cv",     n_cv - cv0, 32'd1);
        chk("t6b_a_code",   {29'd0, bus.cmd_code}, 32'd1);
        clocks(HOLD + 10);
        chk("t6b_hold_len", zero_cyc - last_cv_cyc, HOLD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
